// File: rtl/lcd_nibble_rx.sv
// lcd_nibble_rx: responder end of a 4-bit HD44780-style LCD bus.
// The block oversamples the controller's bus and follows the power-up
// 8-bit/4-bit mode sequence. It rebuilds bytes from nibble pairs, tracks the
// DDRAM address counter and emulates the busy flag. It also answers status
// reads with {busy, addr[6:4]} followed by addr[3:0].
module lcd_nibble_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int BUSY_SHORT  = 2000,
    parameter int BUSY_LONG   = 82000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] lcd_data_in,
    input  logic [2:0] lcd_ctrl,
    output logic [3:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic [6:0] ddram_addr,
    output logic       busy,
    output logic       mode4,
    output logic       proto_err
);

    typedef enum logic [1:0] {
        MODE8  = 2'd0,
        NIB_HI = 2'd1,
        NIB_LO = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [2:0] ctrl_sync_reg [SYNC_STAGES];
    logic [3:0] data_sync_reg [SYNC_STAGES];

    logic [2:0] ctrl_s;
    logic [3:0] data_s;
    logic       e_s;

    assign ctrl_s = ctrl_sync_reg[SYNC_STAGES-1];
    assign data_s = data_sync_reg[SYNC_STAGES-1];
    assign e_s    = ctrl_s[0];

    // Bring the control and data buses through equal-depth flop chains.
    // Both buses see the same delay, so data captured at the strobe matches
    // the value the controller presented at its E fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ctrl_sync_reg[i] <= '0;
                data_sync_reg[i] <= '0;
            end
        end else begin
            ctrl_sync_reg[0] <= lcd_ctrl;
            data_sync_reg[0] <= lcd_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ctrl_sync_reg[i] <= ctrl_sync_reg[i-1];
                data_sync_reg[i] <= data_sync_reg[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // E edge detection and RS/RW latching
    // ------------------------------------------------------------------
    logic e_d_reg;
    logic rs_lat_reg;
    logic rw_lat_reg;
    logic e_rise;
    logic strobe;

    assign e_rise = e_s & ~e_d_reg;
    assign strobe = ~e_s & e_d_reg;

    // Hold RS/RW as seen at E rise. Changes on those lines while E is high
    // are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_d_reg    <= 1'b0;
            rs_lat_reg <= 1'b0;
            rw_lat_reg <= 1'b0;
        end else begin
            e_d_reg <= e_s;
            if (e_rise) begin
                rs_lat_reg <= ctrl_s[2];
                rw_lat_reg <= ctrl_s[1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Core state
    // ------------------------------------------------------------------
    state_t           state_reg;
    logic [3:0]       hi_nib_reg;
    logic             hi_rs_reg;
    logic             phase_reg;
    logic [CNT_W-1:0] cnt_reg;

    // ------------------------------------------------------------------
    // Strobe classification: decide whether this strobe emits a byte
    // ------------------------------------------------------------------
    logic       wr_ok;
    logic       emit;
    logic [7:0] emit_byte;
    logic       emit_rs;
    logic       pair_bad;
    logic       err_next;

    // A write strobe only emits when not busy. In MODE8 each nibble emits
    // {nib,0}. In NIB_LO a nibble emits only if its RS matches the held high
    // nibble's RS.
    always_comb begin
        emit      = 1'b0;
        emit_byte = 8'h00;
        emit_rs   = 1'b0;
        pair_bad  = 1'b0;
        wr_ok     = strobe && !rw_lat_reg && !busy;
        if (wr_ok) begin
            case (state_reg)
                MODE8: begin
                    emit      = 1'b1;
                    emit_byte = {data_s, 4'h0};
                    emit_rs   = rs_lat_reg;
                end
                NIB_LO: begin
                    if (rs_lat_reg == hi_rs_reg) begin
                        emit      = 1'b1;
                        emit_byte = {hi_nib_reg, data_s};
                        emit_rs   = rs_lat_reg;
                    end else begin
                        pair_bad = 1'b1;
                    end
                end
                default: begin
                    emit = 1'b0;
                end
            endcase
        end
        err_next = strobe && ((!rw_lat_reg && busy) ||
                              (rw_lat_reg && rs_lat_reg) ||
                              pair_bad);
    end

    // ------------------------------------------------------------------
    // Byte decode: address update, busy length, function-set detection
    // ------------------------------------------------------------------
    logic [6:0]       addr_dec;
    logic [CNT_W-1:0] load_val;
    logic             fnset;
    logic             is_clr_home;

    // Decode the emitted byte the way the LCD would. This covers clear and
    // home, set-DDRAM-address and function set. A character write advances
    // the address, and the 7-bit address wraps from 7F to 00.
    always_comb begin
        addr_dec    = ddram_addr;
        load_val    = CNT_W'(BUSY_SHORT);
        fnset       = 1'b0;
        is_clr_home = (emit_byte == 8'h01) || (emit_byte[7:1] == 7'b0000001);
        if (emit_rs) begin
            addr_dec = ddram_addr + 7'd1;
        end else if (is_clr_home) begin
            addr_dec = 7'd0;
            load_val = CNT_W'(BUSY_LONG);
        end else if (emit_byte[7]) begin
            addr_dec = emit_byte[6:0];
        end else if (emit_byte[7:5] == 3'b001) begin
            fnset = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Busy counter next value
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_next;

    // A load on emission takes priority over the decrement in the same cycle.
    always_comb begin
        cnt_next = cnt_reg;
        if (emit) begin
            cnt_next = load_val;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read-back path
    // ------------------------------------------------------------------
    logic       rd_rw;
    logic       rd_rs;
    logic       oe_next;
    logic [3:0] dout_next;

    // While E is high, drive the status nibble selected by the read phase.
    // In the E-rise cycle the latched RS/RW are not valid yet, so the synced
    // lines are used directly in that cycle.
    always_comb begin
        rd_rw     = e_rise ? ctrl_s[1] : rw_lat_reg;
        rd_rs     = e_rise ? ctrl_s[2] : rs_lat_reg;
        oe_next   = e_s && rd_rw;
        dout_next = 4'h0;
        if (oe_next && !rd_rs) begin
            if (!phase_reg || state_reg == MODE8) begin
                dout_next = {busy, ddram_addr[6:4]};
            end else begin
                dout_next = ddram_addr[3:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Main sequential block: mode FSM, nibble pairing and registered outputs
    // ------------------------------------------------------------------
    // Accepted write strobes advance the MODE8/NIB_HI/NIB_LO sequence.
    // Function-set bytes then override the next state: with DL=1 the block
    // falls back to MODE8, otherwise it enters nibble-pair mode. The 0x20
    // nibble during the 8-bit phase lands in NIB_HI through this override.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= MODE8;
            hi_nib_reg   <= 4'h0;
            hi_rs_reg    <= 1'b0;
            phase_reg    <= 1'b0;
            cnt_reg      <= '0;
            lcd_data_out <= 4'h0;
            lcd_data_oe  <= 1'b0;
            byte_valid   <= 1'b0;
            byte_rs      <= 1'b0;
            byte_data    <= 8'h00;
            ddram_addr   <= 7'd0;
            busy         <= 1'b0;
            mode4        <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            byte_valid   <= emit;
            proto_err    <= err_next;
            cnt_reg      <= cnt_next;
            busy         <= (cnt_next != '0);
            lcd_data_oe  <= oe_next;
            lcd_data_out <= dout_next;

            if (emit) begin
                byte_data  <= emit_byte;
                byte_rs    <= emit_rs;
                ddram_addr <= addr_dec;
            end

            if (wr_ok) begin
                phase_reg <= 1'b0;
                case (state_reg)
                    NIB_HI: begin
                        hi_nib_reg <= data_s;
                        hi_rs_reg  <= rs_lat_reg;
                        state_reg  <= NIB_LO;
                    end
                    NIB_LO: begin
                        state_reg <= NIB_HI;
                    end
                    default: begin
                        state_reg <= MODE8;
                    end
                endcase
                if (emit && fnset) begin
                    if (emit_byte[4]) begin
                        state_reg <= MODE8;
                        mode4     <= 1'b0;
                    end else begin
                        state_reg <= NIB_HI;
                        mode4     <= 1'b1;
                    end
                end
            end else if (strobe && rw_lat_reg && !rs_lat_reg && state_reg != MODE8) begin
                phase_reg <= ~phase_reg;
            end
        end
    end

endmodule
